// File: rtl/axi_master_pkg.sv
// Shared types and constants for the CPU-side AXI master bridge.
// Bus widths and response codes mirror the values used by the interconnect's AXI_define.svh.
package axi_master_pkg;

    localparam int AXI_ID_BITS    = 4;
    localparam int AXI_ADDR_BITS  = 32;
    localparam int AXI_LEN_BITS   = 4;
    localparam int AXI_SIZE_BITS  = 3;
    localparam int AXI_BURST_BITS = 2;
    localparam int AXI_DATA_BITS  = 32;
    localparam int AXI_STRB_BITS  = AXI_DATA_BITS / 8;
    localparam int AXI_RESP_BITS  = 2;

    localparam logic [AXI_RESP_BITS-1:0]  RESP_OKAY   = 2'b00;
    localparam logic [AXI_RESP_BITS-1:0]  RESP_EXOKAY = 2'b01;
    localparam logic [AXI_RESP_BITS-1:0]  RESP_SLVERR = 2'b10;
    localparam logic [AXI_RESP_BITS-1:0]  RESP_DECERR = 2'b11;

    localparam logic [AXI_SIZE_BITS-1:0]  SIZE_WORD  = 3'b010;
    localparam logic [AXI_BURST_BITS-1:0] BURST_INCR = 2'b01;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RADDR = 3'd1,
        RDATA = 3'd2,
        WADDR = 3'd3,
        WDATA = 3'd4,
        WRESP = 3'd5
    } state_t;

endpackage

// File: rtl/cpu_axi_master.sv
// Bridges a single-outstanding CPU/cache memory port onto AXI: INCR read bursts
// and single-beat writes, with read-beat and completion pulses back to the core.
module cpu_axi_master
    import axi_master_pkg::*;
#(
    parameter logic [AXI_ID_BITS-1:0] MASTER_ID = 4'd0
) (
    input  logic                      ACLK,
    input  logic                      ARESETn,

    input  logic                      core_req,
    input  logic                      core_write,
    input  logic [AXI_ADDR_BITS-1:0]  core_addr,
    input  logic [AXI_LEN_BITS-1:0]   core_len,
    input  logic [AXI_DATA_BITS-1:0]  core_wdata,
    input  logic [AXI_STRB_BITS-1:0]  core_wstrb,
    output logic [AXI_DATA_BITS-1:0]  core_rdata,
    output logic                      core_rvalid,
    output logic                      core_done,
    output logic                      core_err,
    output logic                      core_busy,

    output logic [AXI_ID_BITS-1:0]    M_AWID,
    output logic [AXI_ADDR_BITS-1:0]  M_AWAddr,
    output logic [AXI_LEN_BITS-1:0]   M_AWLen,
    output logic [AXI_SIZE_BITS-1:0]  M_AWSize,
    output logic [AXI_BURST_BITS-1:0] M_AWBurst,
    output logic                      M_AWValid,
    input  logic                      M_AWReady,

    output logic [AXI_DATA_BITS-1:0]  M_WData,
    output logic [AXI_STRB_BITS-1:0]  M_WStrb,
    output logic                      M_WLast,
    output logic                      M_WValid,
    input  logic                      M_WReady,

    input  logic [AXI_ID_BITS-1:0]    M_BID,
    input  logic [AXI_RESP_BITS-1:0]  M_BResp,
    input  logic                      M_BValid,
    output logic                      M_BReady,

    output logic [AXI_ID_BITS-1:0]    M_ARID,
    output logic [AXI_ADDR_BITS-1:0]  M_ARAddr,
    output logic [AXI_LEN_BITS-1:0]   M_ARLen,
    output logic [AXI_SIZE_BITS-1:0]  M_ARSize,
    output logic [AXI_BURST_BITS-1:0] M_ARBurst,
    output logic                      M_ARValid,
    input  logic                      M_ARReady,

    input  logic [AXI_ID_BITS-1:0]    M_RID,
    input  logic [AXI_DATA_BITS-1:0]  M_RData,
    input  logic [AXI_RESP_BITS-1:0]  M_RResp,
    input  logic                      M_RLast,
    input  logic                      M_RValid,
    output logic                      M_RReady
);

    state_t                     state, state_next;
    logic [AXI_ADDR_BITS-1:0]   reg_addr;
    logic [AXI_LEN_BITS-1:0]    reg_len;
    logic [AXI_DATA_BITS-1:0]   reg_wdata;
    logic [AXI_STRB_BITS-1:0]   reg_wstrb;
    logic [AXI_LEN_BITS-1:0]    beat_cnt;
    logic                       sticky_err;

    logic r_beat, r_fin, w_fin, r_resp_err;

    // Only one transaction is ever in flight, so response IDs carry no information.
    logic unused_ids;
    assign unused_ids = ^{M_RID, M_BID};

    assign r_beat     = (state == RDATA) && M_RValid;
    assign r_fin      = r_beat && M_RLast;
    assign w_fin      = (state == WRESP) && M_BValid;
    assign r_resp_err = (M_RResp != RESP_OKAY);

    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (core_req)   state_next = core_write ? WADDR : RADDR;
            RADDR:   if (M_ARReady)  state_next = RDATA;
            RDATA:   if (r_fin)      state_next = IDLE;
            WADDR:   if (M_AWReady)  state_next = WDATA;
            WDATA:   if (M_WReady)   state_next = WRESP;
            WRESP:   if (M_BValid)   state_next = IDLE;
            default:                 state_next = IDLE;
        endcase
    end

    // A beat arriving after the counted final beat without RLast marks overrun,
    // so a wrapped counter landing back on reg_len still reports an error.
    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            reg_addr   <= '0;
            reg_len    <= '0;
            reg_wdata  <= '0;
            reg_wstrb  <= '0;
            beat_cnt   <= '0;
            sticky_err <= 1'b0;
        end else begin
            if (state == IDLE && core_req) begin
                reg_addr  <= core_addr;
                reg_len   <= core_len;
                reg_wdata <= core_wdata;
                reg_wstrb <= core_wstrb;
            end
            if (r_beat) begin
                if (M_RLast) begin
                    beat_cnt   <= '0;
                    sticky_err <= 1'b0;
                end else begin
                    beat_cnt   <= beat_cnt + 1'b1;
                    sticky_err <= sticky_err | r_resp_err | (beat_cnt == reg_len);
                end
            end
        end
    end

    assign M_ARValid = (state == RADDR);
    assign M_RReady  = (state == RDATA);
    assign M_AWValid = (state == WADDR);
    assign M_WValid  = (state == WDATA);
    assign M_BReady  = (state == WRESP);
    assign core_busy = (state != IDLE);

    assign M_ARID    = MASTER_ID;
    assign M_ARAddr  = reg_addr;
    assign M_ARLen   = reg_len;
    assign M_ARSize  = SIZE_WORD;
    assign M_ARBurst = BURST_INCR;

    assign M_AWID    = MASTER_ID;
    assign M_AWAddr  = reg_addr;
    assign M_AWLen   = '0;
    assign M_AWSize  = SIZE_WORD;
    assign M_AWBurst = BURST_INCR;

    assign M_WData   = reg_wdata;
    assign M_WStrb   = reg_wstrb;
    assign M_WLast   = 1'b1;

    // Core-facing pulses are suppressed while reset is held so an aborted burst never completes.
    assign core_rdata  = M_RData;
    assign core_rvalid = ARESETn && r_beat;
    assign core_done   = ARESETn && (r_fin || w_fin);
    assign core_err    = ARESETn && ((r_fin && (sticky_err || r_resp_err || (beat_cnt != reg_len)))
                                  || (w_fin && (M_BResp != RESP_OKAY)));

endmodule
